// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, streams word requests to imem and queues responses in order.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects halt fetch and raise a sticky fetch_misalign.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] pending;
    logic [CW-1:0] drop;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic          halted;

    logic [CW:0]   occupancy;
    logic [31:0]   target;
    logic          accept;
    logic          resp_fire;
    logic          push;
    logic          pop;

    assign target    = redirect_pc & ~32'h3;
    assign occupancy = (CW+1)'(count) + (CW+1)'(pending);

    assign imem_req_valid = !reset && !redirect && !halted
                          && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr      = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are stale (e.g. issued before reset).
    assign resp_fire = imem_resp_valid && (pending != '0);
    assign push      = resp_fire && (drop == '0) && !redirect;

    assign out_valid       = (count != '0) && !redirect;
    assign out_pc          = pc_q[rd_ptr];
    assign out_instruction = data_q[rd_ptr];
    assign pop             = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            pending  <= '0;
            drop     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (redirect) begin
            // Everything still in flight gets discarded as it returns.
            fetch_pc <= target;
            resp_pc  <= target;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pending  <= pending - CW'(resp_fire);
            drop     <= pending - CW'(resp_fire);
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + 32'd4;
            pending <= pending + CW'(accept) - CW'(resp_fire);
            if (resp_fire && (drop != '0))
                drop <= drop - CW'(1);
            if (push) begin
                pc_q[wr_ptr]   <= resp_pc;
                data_q[wr_ptr] <= imem_resp_data;
                wr_ptr         <= wr_ptr + PW'(1);
                resp_pc        <= resp_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else if (redirect) begin
            halted   <= |redirect_pc[1:0];
            misalign <= |redirect_pc[1:0];
        end
    end

    assign fetch_misalign = misalign;
`else
    assign halted         = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed table, corner sequences and random traffic
// against a PC-stream scoreboard and a queued memory model.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_misalign;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .fetch_misalign  (fetch_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic        erv;
        logic [31:0] eaddr;
    } vec_t;

    req_t        mq[$];
    vec_t        tv[12];
    int          cyc = 0;
    int          lat = 1;
    bit          rand_lat = 0;
    logic        mem_rdy = 1'b1;
    bit          sb_on = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          pops = 0;
    int          nchk = 0;
    int          nerr = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic check_b(input string n, input logic a, input logic e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rd,
                         input logic [31:0] rpc);
        @(negedge clk);
        reset          = r;
        out_ready      = rdy;
        redirect       = rd;
        redirect_pc    = rpc;
        imem_req_ready = mem_rdy;
        if (!r && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
    endtask

    task automatic commit();
        req_t e;
        if (reset) begin
            mq.delete();
        end else begin
            if (imem_resp_valid)
                void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                e.addr = imem_addr;
                e.due  = cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat);
                mq.push_back(e);
            end
            if (sb_on) begin
                if (imem_req_valid)
                    check("rand_align", {30'b0, imem_addr[1:0]}, 32'h0);
                if (imem_req_valid && imem_req_ready) begin
                    check("rand_req_addr", imem_addr, exp_req);
                    exp_req = exp_req + 32'd4;
                end
                if (out_valid && out_ready) begin
                    check("rand_pc", out_pc, exp_pc);
                    check("rand_instr", out_instruction, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
                if (redirect) begin
                    check_b("rand_redir_quiet", imem_req_valid | out_valid, 1'b0);
                    exp_pc  = redirect_pc & ~32'h3;
                    exp_req = redirect_pc & ~32'h3;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        lat     = 1;
        mem_rdy = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        commit();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        commit();
    endtask

    initial begin
        bit found;

        tv[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h8};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'hC};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h10};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 32'hFFFFFFF8, 1'b0, 32'h0,         1'b0, 32'h14};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFFFFF8};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFFFFFC};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFFFFF8, 1'b1, 32'h0};
        tv[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFFFFFC, 1'b1, 32'h4};
        tv[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h8};

        // Directed table: startup latency, streaming, redirect with a same-cycle response, wrap.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].rst, tv[i].rdy, tv[i].redir, tv[i].rpc);
            check_b($sformatf("tv%0d_out_valid", i), out_valid, tv[i].ev);
            check_b($sformatf("tv%0d_req_valid", i), imem_req_valid, tv[i].erv);
            check($sformatf("tv%0d_addr", i), imem_addr, tv[i].eaddr);
            if (tv[i].ev || tv[i].rst) begin
                check($sformatf("tv%0d_out_pc", i), out_pc, tv[i].epc);
                if (tv[i].ev)
                    check($sformatf("tv%0d_instr", i), out_instruction, mem_word(tv[i].epc));
            end
            if (tv[i].rst)
                check_b("tv_reset_misalign", fetch_misalign, 1'b0);
            commit();
        end

        // Backpressure: queue fills to DEPTH, then drains without gaps.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            commit();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check_b("bp_full_valid", out_valid, 1'b1);
        check_b("bp_full_noreq", imem_req_valid, 1'b0);
        check_b("bp_no_resp", imem_resp_valid, 1'b0);
        commit();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            check_b($sformatf("bp_drain%0d_valid", k), out_valid, 1'b1);
            check($sformatf("bp_drain%0d_pc", k), out_pc, 32'(k * 4));
            commit();
        end

        // Three-cycle memory: redirect with two requests in flight.
        do_reset();
        lat = 3;
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        commit();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        commit();
        drive(1'b0, 1'b1, 1'b1, 32'h100);
        check_b("lat3_redir_noreq", imem_req_valid, 1'b0);
        commit();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            if (out_valid) begin
                found = 1;
                check("lat3_first_pc", out_pc, 32'h100);
                check("lat3_first_instr", out_instruction, mem_word(32'h100));
            end
            commit();
        end
        if (!found)
            check_b("lat3_timeout", 1'b0, 1'b1);

        // Misaligned redirect.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            commit();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h102);
        commit();
`ifdef FETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            check_b($sformatf("mis_flag%0d", k), fetch_misalign, 1'b1);
            check_b($sformatf("mis_noreq%0d", k), imem_req_valid, 1'b0);
            check_b($sformatf("mis_noout%0d", k), out_valid, 1'b0);
            commit();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h200);
        commit();
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            check_b("mis_cleared", fetch_misalign, 1'b0);
            if (out_valid) begin
                found = 1;
                check("mis_first_pc", out_pc, 32'h200);
            end
            commit();
        end
`else
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            check_b("mis_flag_tied", fetch_misalign, 1'b0);
            if (out_valid) begin
                found = 1;
                check("mis_first_pc", out_pc, 32'h100);
            end
            commit();
        end
`endif
        if (!found)
            check_b("mis_timeout", 1'b0, 1'b1);

        // Mid-operation reset returns to the reset PC.
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        commit();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check_b("rst_mid_out_valid", out_valid, 1'b0);
        check_b("rst_mid_req_valid", imem_req_valid, 1'b1);
        check("rst_mid_addr", imem_addr, 32'h0);
        commit();

        // Random traffic against the PC-stream scoreboard.
        do_reset();
        rand_lat = 1;
        exp_pc   = 32'h0;
        exp_req  = 32'h0;
        sb_on    = 1;
        for (int k = 0; k < 3000; k++) begin
            logic        rd;
            logic [31:0] rpc;
            mem_rdy = ($urandom_range(0, 3) != 0);
            rd      = ($urandom_range(0, 24) == 0);
            rpc     = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 | ($urandom & 32'hF)
                                                  : $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            rpc = rpc & ~32'h3;
`endif
            drive(1'b0, ($urandom_range(0, 3) != 0), rd, rpc);
            commit();
        end
        sb_on = 0;
        check_b("rand_progress", pops >= 500, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
